cpu_branch_redirect_ctrl: RTL and testbench

//   Fetch-redirect controller for the static branch predictor. Queues every predicted

---
 rtl/cpu_branch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_branch_redirect_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_branch_redirect_ctrl.sv
// rtl/cpu_branch_redirect_ctrl.sv - fetch redirect controller: prediction queue, mismatch redirect, flush window
module cpu_branch_redirect_ctrl #(
  parameter logic [31:0] p_reset_vector = 32'hf0000000,
  parameter int          p_depth        = 4,
  parameter int          p_flush_cycles = 2,
  parameter int          p_cnt_width    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fetch_valid,
  input  logic                       i_branch_instr,
  input  logic [31:0]                i_predicted_pc,
  input  logic                       i_res_valid,
  input  logic [31:0]                i_res_pc,
  output logic                       o_pc_load,
  output logic [31:0]                o_next_pc,
  output logic                       o_flush,
  output logic                       o_stall,
  output logic [$clog2(p_depth):0]   o_pending,
  output logic                       o_error,
  output logic [p_cnt_width-1:0]     o_branches,
  output logic [p_cnt_width-1:0]     o_mispredicts
);

  localparam int c_ptr_w = $clog2(p_depth);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_fc_w  = (p_flush_cycles > 1) ? $clog2(p_flush_cycles) : 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [c_fc_w-1:0]      fcnt_q, fcnt_d;
  logic [c_ptr_w-1:0]     head_q, head_d, tail_q, tail_d;
  logic [c_cnt_w-1:0]     count_q, count_d;
  logic [31:0]            slot_q [p_depth];
  logic                   pc_load_q, pc_load_d;
  logic [31:0]            next_pc_q, next_pc_d;
  logic                   flush_q, flush_d;
  logic                   error_q, error_d;
  logic [p_cnt_width-1:0] branches_q, branches_d;
  logic [p_cnt_width-1:0] mispredicts_q, mispredicts_d;

  logic full, res_hit, mismatch, pop, push;

  always_comb begin
    full     = (count_q == c_cnt_w'(p_depth));
    res_hit  = (state_q == S_RUN) && i_res_valid && (count_q != '0);
    mismatch = res_hit && (slot_q[head_q] != i_res_pc);
    pop      = res_hit && !mismatch;
    // A full queue still accepts a push when the head is retiring correctly this cycle.
    push     = (state_q == S_RUN) && i_fetch_valid && i_branch_instr && !mismatch && (!full || pop);
  end

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    pc_load_d     = 1'b0;
    next_pc_d     = next_pc_q;
    flush_d       = 1'b0;
    error_d       = error_q;
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    case (state_q)
      S_BOOT: begin
        // Fetch stays stalled through the cycle that presents the boot load.
        if (!pc_load_q) begin
          pc_load_d = 1'b1;
          next_pc_d = p_reset_vector;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_res_valid && (count_q == '0)) error_d = 1'b1;
        if (res_hit && (branches_q != '1)) branches_d = branches_q + 1'b1;
        if (mismatch) begin
          if (mispredicts_q != '1) mispredicts_d = mispredicts_q + 1'b1;
          head_d    = '0;
          tail_d    = '0;
          count_d   = '0;
          pc_load_d = 1'b1;
          next_pc_d = i_res_pc;
          flush_d   = 1'b1;
          fcnt_d    = c_fc_w'(p_flush_cycles - 1);
          state_d   = S_FLUSH;
        end else begin
          if (push) tail_d = tail_q + 1'b1;
          if (pop)  head_d = head_q + 1'b1;
          count_d = count_q + {{(c_cnt_w-1){1'b0}}, push} - {{(c_cnt_w-1){1'b0}}, pop};
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) state_d = S_RUN;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_BOOT;
      fcnt_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      pc_load_q     <= 1'b0;
      next_pc_q     <= p_reset_vector;
      flush_q       <= 1'b0;
      error_q       <= 1'b0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      pc_load_q     <= pc_load_d;
      next_pc_q     <= next_pc_d;
      flush_q       <= flush_d;
      error_q       <= error_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) slot_q[tail_q] <= i_predicted_pc;
  end

  assign o_pc_load     = pc_load_q;
  assign o_next_pc     = next_pc_q;
  assign o_flush       = flush_q;
  assign o_stall       = (state_q != S_RUN) || full;
  assign o_pending     = count_q;
  assign o_error       = error_q;
  assign o_branches    = branches_q;
  assign o_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_cpu_branch_redirect_ctrl.sv
// tb/tb_cpu_branch_redirect_ctrl.sv - directed self-checking bench for cpu_branch_redirect_ctrl
module tb_cpu_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, branch_instr, res_valid;
  logic [31:0] predicted_pc, res_pc;

  logic        pc_load, flush, stall, error;
  logic [31:0] next_pc;
  logic [2:0]  pending;
  logic [15:0] branches, mispredicts;

  logic        s_pc_load, s_flush, s_stall, s_error;
  logic [31:0] s_next_pc;
  logic [2:0]  s_pending;
  logic [1:0]  s_branches, s_mispredicts;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_branch_redirect_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_valid(fetch_valid), .i_branch_instr(branch_instr),
    .i_predicted_pc(predicted_pc), .i_res_valid(res_valid), .i_res_pc(res_pc),
    .o_pc_load(pc_load), .o_next_pc(next_pc), .o_flush(flush), .o_stall(stall),
    .o_pending(pending), .o_error(error), .o_branches(branches), .o_mispredicts(mispredicts)
  );

  cpu_branch_redirect_ctrl #(.p_cnt_width(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_fetch_valid(fetch_valid), .i_branch_instr(branch_instr),
    .i_predicted_pc(predicted_pc), .i_res_valid(res_valid), .i_res_pc(res_pc),
    .o_pc_load(s_pc_load), .o_next_pc(s_next_pc), .o_flush(s_flush), .o_stall(s_stall),
    .o_pending(s_pending), .o_error(s_error), .o_branches(s_branches), .o_mispredicts(s_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0; branch_instr = 1'b0; res_valid = 1'b0;
  endtask

  task automatic drive(input logic push, input logic [31:0] ppc, input logic res, input logic [31:0] rpc);
    fetch_valid = push; branch_instr = push; predicted_pc = ppc;
    res_valid = res; res_pc = rpc;
    step();
    idle();
  endtask

  task automatic mispredict(input logic [31:0] target);
    drive(1'b1, target, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, target + 32'h4);
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; idle(); predicted_pc = '0; res_pc = '0;
    step(); step();
    check("rst_pc_load", {31'b0, pc_load}, 32'h0);
    check("rst_next_pc", next_pc, 32'hf0000000);
    check("rst_stall", {31'b0, stall}, 32'h1);
    check("rst_pending", {29'b0, pending}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    check("rst_branches", {16'b0, branches}, 32'h0);

    rst = 1'b0;
    step();
    check("boot_pc_load", {31'b0, pc_load}, 32'h1);
    check("boot_next_pc", next_pc, 32'hf0000000);
    check("boot_stall", {31'b0, stall}, 32'h1);
    step();
    check("run_pc_load", {31'b0, pc_load}, 32'h0);
    check("run_stall", {31'b0, stall}, 32'h0);
    check("run_pending", {29'b0, pending}, 32'h0);

    for (int i = 1; i <= 4; i++) drive(1'b1, 32'h100 * i, 1'b0, 32'h0);
    check("fill_pending", {29'b0, pending}, 32'h4);
    check("fill_stall", {31'b0, stall}, 32'h1);
    drive(1'b1, 32'h999, 1'b0, 32'h0);
    check("drop_pending", {29'b0, pending}, 32'h4);
    drive(1'b1, 32'h500, 1'b1, 32'h100);
    check("swap_pending", {29'b0, pending}, 32'h4);
    check("swap_flush", {31'b0, flush}, 32'h0);
    check("swap_branches", {16'b0, branches}, 32'h1);
    for (int i = 2; i <= 5; i++) drive(1'b0, 32'h0, 1'b1, 32'h100 * i);
    check("drain_pending", {29'b0, pending}, 32'h0);
    check("drain_branches", {16'b0, branches}, 32'h5);
    check("drain_mispredicts", {16'b0, mispredicts}, 32'h0);
    check("drain_stall", {31'b0, stall}, 32'h0);

    drive(1'b1, 32'h100, 1'b0, 32'h0);
    drive(1'b1, 32'h200, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h104);
    check("mis_flush", {31'b0, flush}, 32'h1);
    check("mis_pc_load", {31'b0, pc_load}, 32'h1);
    check("mis_next_pc", next_pc, 32'h104);
    check("mis_pending", {29'b0, pending}, 32'h0);
    check("mis_stall1", {31'b0, stall}, 32'h1);
    check("mis_count", {16'b0, mispredicts}, 32'h1);
    check("mis_branches", {16'b0, branches}, 32'h6);
    step();
    check("mis_flush_pulse", {31'b0, flush}, 32'h0);
    check("mis_load_pulse", {31'b0, pc_load}, 32'h0);
    check("mis_stall2", {31'b0, stall}, 32'h1);
    step();
    check("mis_stall_end", {31'b0, stall}, 32'h0);

    drive(1'b1, 32'h700, 1'b0, 32'h0);
    drive(1'b1, 32'h600, 1'b1, 32'h704);
    check("wp_flush", {31'b0, flush}, 32'h1);
    check("wp_pending", {29'b0, pending}, 32'h0);
    step(); step();
    check("wp_pending_after", {29'b0, pending}, 32'h0);
    check("wp_error_clear", {31'b0, error}, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h123);
    check("empty_error", {31'b0, error}, 32'h1);
    check("empty_branches", {16'b0, branches}, 32'h7);
    check("empty_flush", {31'b0, flush}, 32'h0);
    step();
    check("error_sticky", {31'b0, error}, 32'h1);

    check("sat_pre_branches", {30'b0, s_branches}, 32'h3);
    check("sat_pre_mis", {30'b0, s_mispredicts}, 32'h2);
    for (int i = 0; i < 3; i++) mispredict(32'h1000 + 32'h100 * i);
    check("sat_mis", {30'b0, s_mispredicts}, 32'h3);
    check("sat_branches", {30'b0, s_branches}, 32'h3);
    check("wide_mis", {16'b0, mispredicts}, 32'h5);
    check("wide_branches", {16'b0, branches}, 32'ha);

    for (int i = 1; i <= 3; i++) drive(1'b1, 32'h2000 + i, 1'b0, 32'h0);
    check("q3_pending", {29'b0, pending}, 32'h3);
    #2 rst = 1'b1;
    #1;
    check("arst_pending", {29'b0, pending}, 32'h0);
    check("arst_stall", {31'b0, stall}, 32'h1);
    check("arst_error", {31'b0, error}, 32'h0);
    check("arst_mis", {16'b0, mispredicts}, 32'h0);
    step();
    rst = 1'b0;
    step(); step();
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'h3000 + i, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h3abc);
    check("pre_rst_flush", {31'b0, flush}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("frst_flush", {31'b0, flush}, 32'h0);
    check("frst_pc_load", {31'b0, pc_load}, 32'h0);
    check("frst_next_pc", next_pc, 32'hf0000000);
    check("frst_stall", {31'b0, stall}, 32'h1);
    check("frst_pending", {29'b0, pending}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("reboot_pc_load", {31'b0, pc_load}, 32'h1);
    check("reboot_next_pc", next_pc, 32'hf0000000);
    check("reboot_flush", {31'b0, flush}, 32'h0);
    step();
    check("reboot_load_end", {31'b0, pc_load}, 32'h0);
    check("reboot_next_hold", next_pc, 32'hf0000000);
    check("reboot_stall", {31'b0, stall}, 32'h0);
    step();
    check("reboot_no_redirect", {31'b0, pc_load}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
